// File: rtl/dcache.sv
// Direct-mapped, write-through, one-word-per-line data cache between the LSU and a req/ack memory.
// Define DCACHE_WRALLOC_EN to make store misses install the line (write-allocate).
module dcache #(
  parameter int WIDTH_MEM = 4,
  parameter int WIDTH_IDX = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_val,
  input  logic [WIDTH_MEM-1:0] i_addr,
  input  logic [31:0]          i_data,
  input  logic                 i_we,
  input  logic                 i_kill,
  output logic [31:0]          o_data,
  output logic                 o_nack,
  output logic                 mem_o_req,
  output logic                 mem_o_we,
  output logic [WIDTH_MEM-1:0] mem_o_addr,
  output logic [31:0]          mem_o_data,
  input  logic [31:0]          mem_i_data,
  input  logic                 mem_i_ack
);

  localparam int WIDTH_TAG = WIDTH_MEM - WIDTH_IDX;
  localparam int LINES     = 1 << WIDTH_IDX;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t               state;
  logic [LINES-1:0]     valid;
  logic [WIDTH_TAG-1:0] tags  [LINES];
  logic [31:0]          lines [LINES];

  logic [WIDTH_IDX-1:0] req_idx;
  logic [WIDTH_TAG-1:0] req_tag;
  logic                 hit;
  logic                 accept;

  assign req_idx = i_addr[WIDTH_IDX-1:0];
  assign req_tag = i_addr[WIDTH_MEM-1:WIDTH_IDX];
  assign hit     = valid[req_idx] && (tags[req_idx] == req_tag);
  assign accept  = i_val && !i_kill;

  logic                 arr_we;
  logic [WIDTH_IDX-1:0] arr_idx;
  logic [WIDTH_TAG-1:0] arr_tag;
  logic [31:0]          arr_data;

  // Single array write port: IDLE stores update the line, a refill installs it from the
  // latched miss address on the ack cycle.
  always_comb begin
    arr_we   = 1'b0;
    arr_idx  = req_idx;
    arr_tag  = req_tag;
    arr_data = i_data;
    case (state)
      IDLE: begin
        if (accept && i_we) begin
`ifdef DCACHE_WRALLOC_EN
          arr_we = 1'b1;
`else
          arr_we = hit;
`endif
        end
      end
      REFILL: begin
        if (mem_i_ack) begin
          arr_we   = 1'b1;
          arr_idx  = mem_o_addr[WIDTH_IDX-1:0];
          arr_tag  = mem_o_addr[WIDTH_MEM-1:WIDTH_IDX];
          arr_data = mem_i_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (arr_we) begin
      lines[arr_idx] <= arr_data;
      tags[arr_idx]  <= arr_tag;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid <= '0;
    end else if (arr_we) begin
      valid[arr_idx] <= 1'b1;
    end
  end

  // Controller; the memory-side outputs double as the latched miss/store address and data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_data     <= '0;
      o_nack     <= 1'b0;
      mem_o_req  <= 1'b0;
      mem_o_we   <= 1'b0;
      mem_o_addr <= '0;
      mem_o_data <= '0;
    end else begin
      o_nack <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!i_we) begin
              if (hit) begin
                o_data <= lines[req_idx];
              end else begin
                o_nack     <= 1'b1;
                mem_o_req  <= 1'b1;
                mem_o_we   <= 1'b0;
                mem_o_addr <= i_addr;
                state      <= REFILL;
              end
            end else begin
              mem_o_req  <= 1'b1;
              mem_o_we   <= 1'b1;
              mem_o_addr <= i_addr;
              mem_o_data <= i_data;
              state      <= WRITE;
            end
          end
        end
        REFILL: begin
          o_nack <= accept;
          if (mem_i_ack) begin
            mem_o_req <= 1'b0;
            state     <= IDLE;
          end
        end
        WRITE: begin
          if (accept) begin
            if (!i_we && hit) begin
              o_data <= lines[req_idx];
            end else begin
              o_nack <= 1'b1;
            end
          end
          if (mem_i_ack) begin
            mem_o_req <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: vector table plus hand sequences, response and memory scoreboards.
// Expectations follow DCACHE_WRALLOC_EN when the bench is built with it.
module tb_dcache;

  localparam int WM = 4;
  localparam int WI = 2;

  logic          clk;
  logic          rst_n;
  logic          i_val;
  logic [WM-1:0] i_addr;
  logic [31:0]   i_data;
  logic          i_we;
  logic          i_kill;
  logic [31:0]   o_data;
  logic          o_nack;
  logic          mem_o_req;
  logic          mem_o_we;
  logic [WM-1:0] mem_o_addr;
  logic [31:0]   mem_o_data;
  logic [31:0]   mem_i_data;
  logic          mem_i_ack;

  dcache #(.WIDTH_MEM(WM), .WIDTH_IDX(WI)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_val      (i_val),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .i_we       (i_we),
    .i_kill     (i_kill),
    .o_data     (o_data),
    .o_nack     (o_nack),
    .mem_o_req  (mem_o_req),
    .mem_o_we   (mem_o_we),
    .mem_o_addr (mem_o_addr),
    .mem_o_data (mem_o_data),
    .mem_i_data (mem_i_data),
    .mem_i_ack  (mem_i_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        nack;
    logic        chk;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
  } memop_t;

  typedef struct {
    logic        val;
    logic        we;
    logic        kill;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        exp_nack;
    logic        chk;
    logic [31:0] exp_data;
    int          mem_op;
    logic        wait_idle;
  } vec_t;

  resp_t  sb[$];
  memop_t mem_exp[$];
  vec_t   vecs[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [16];
  int ack_delay = 3;
  int wait_cnt  = 0;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: acks after ack_delay cycles of req and checks each transaction.
  always @(negedge clk) begin
    mem_i_ack = 1'b0;
    if (!rst_n || !mem_o_req) begin
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay - 1) begin
      mem_i_ack  = 1'b1;
      mem_i_data = mem[mem_o_addr];
      if (mem_exp.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL mem_unexpected actual=we%0b@%h required=none", mem_o_we, mem_o_addr);
      end else begin
        memop_t e;
        e = mem_exp.pop_front();
        checkValue("mem_we", {31'd0, mem_o_we}, {31'd0, e.we});
        checkValue("mem_addr", {28'd0, mem_o_addr}, {28'd0, e.addr});
        if (e.we) checkValue("mem_wdata", mem_o_data, e.data);
      end
      if (mem_o_we) mem[mem_o_addr] = mem_o_data;
      wait_cnt = 0;
    end else begin
      wait_cnt++;
    end
  end

  task automatic checkOutput();
    resp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkValue("o_nack", {31'd0, o_nack}, {31'd0, e.nack});
      if (e.chk) checkValue("o_data", o_data, e.data);
    end
  endtask

  // Called at a negedge: check last cycle's response, drive this cycle, advance one cycle.
  task automatic applyStimulus(input vec_t v);
    memop_t m;
    resp_t  r;
    checkOutput();
    i_val  = v.val;
    i_we   = v.we;
    i_kill = v.kill;
    i_addr = v.addr;
    i_data = v.data;
    r.nack = v.exp_nack;
    r.chk  = v.chk;
    r.data = v.exp_data;
    sb.push_back(r);
    if (v.mem_op != 0) begin
      m.we   = (v.mem_op == 2);
      m.addr = v.addr;
      m.data = v.data;
      mem_exp.push_back(m);
    end
    @(negedge clk);
  endtask

  function automatic vec_t mkv(input logic val, input logic we, input logic kill,
                               input logic [3:0] addr, input logic [31:0] data,
                               input logic exp_nack, input logic chk, input logic [31:0] exp_data,
                               input int mem_op, input logic wait_idle);
    vec_t v;
    v.val = val; v.we = we; v.kill = kill; v.addr = addr; v.data = data;
    v.exp_nack = exp_nack; v.chk = chk; v.exp_data = exp_data;
    v.mem_op = mem_op; v.wait_idle = wait_idle;
    return v;
  endfunction

  function automatic vec_t ld(input logic [3:0] a, input logic n, input logic [31:0] d);
    return mkv(1'b1, 1'b0, 1'b0, a, 32'd0, n, !n, d, n ? 1 : 0, n);
  endfunction

  task automatic applyIdle();
    applyStimulus(mkv(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0, 0, 1'b0));
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (mem_o_req === 1'b1 && cycles < 200) begin
      applyIdle();
      cycles++;
    end
    if (cycles >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_idle_timeout actual=%0d required=<200", cycles);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    mem[5] = 32'hDEAD_BEEF;
    mem_i_ack  = 1'b0;
    mem_i_data = '0;
    i_val = 0; i_we = 0; i_kill = 0; i_addr = '0; i_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    checkValue("rst_o_data", o_data, 32'd0);
    checkValue("rst_o_nack", {31'd0, o_nack}, 32'd0);
    checkValue("rst_mem_req", {31'd0, mem_o_req}, 32'd0);
    checkValue("rst_mem_we", {31'd0, mem_o_we}, 32'd0);
    checkValue("rst_mem_addr", {28'd0, mem_o_addr}, 32'd0);
    checkValue("rst_mem_data", mem_o_data, 32'd0);

    // Cold miss: req must stay up exactly three cycles, then the retry hits.
    applyStimulus(ld(4'h5, 1'b1, 32'd0));
    waitIdle(n);
    checkValue("refill_req_cycles", n, 32'd3);
    applyStimulus(ld(4'h5, 1'b0, 32'hDEAD_BEEF));

    vecs.push_back(ld(4'h1, 1'b1, 32'd0));
    vecs.push_back(ld(4'h1, 1'b0, 32'hA000_0001));
    vecs.push_back(ld(4'h5, 1'b1, 32'd0));
    vecs.push_back(ld(4'h5, 1'b0, 32'hDEAD_BEEF));
    vecs.push_back(ld(4'h1, 1'b1, 32'd0));
    vecs.push_back(ld(4'h1, 1'b0, 32'hA000_0001));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b1, 4'h2, 32'd0, 1'b0, 1'b1, 32'hA000_0001, 0, 1'b0));
    vecs.push_back(ld(4'h2, 1'b1, 32'd0));
    vecs.push_back(ld(4'h2, 1'b0, 32'hA000_0002));
    vecs.push_back(mkv(1'b1, 1'b1, 1'b1, 4'h2, 32'h1111_1111, 1'b0, 1'b1, 32'hA000_0002, 0, 1'b0));
    vecs.push_back(ld(4'h2, 1'b0, 32'hA000_0002));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0, 1'b1, 32'hA000_0002, 0, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b1, 1'b0, 4'h9, 32'hCAFE_F00D, 1'b0, 1'b0, 32'd0, 2, 1'b1));
`ifdef DCACHE_WRALLOC_EN
    vecs.push_back(ld(4'h9, 1'b0, 32'hCAFE_F00D));
`else
    vecs.push_back(ld(4'h9, 1'b1, 32'd0));
`endif
    vecs.push_back(ld(4'h9, 1'b0, 32'hCAFE_F00D));
    vecs.push_back(ld(4'h5, 1'b1, 32'd0));
    vecs.push_back(ld(4'h5, 1'b0, 32'hDEAD_BEEF));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      if (vecs[i].wait_idle) waitIdle(n);
    end

    // Requests during a long write-through: load hit served, store and load miss nacked.
    ack_delay = 5;
    applyStimulus(mkv(1'b1, 1'b1, 1'b0, 4'h5, 32'h1234_5678, 1'b0, 1'b0, 32'd0, 2, 1'b0));
    applyStimulus(ld(4'h5, 1'b0, 32'h1234_5678));
    applyStimulus(mkv(1'b1, 1'b1, 1'b0, 4'h6, 32'h0000_0077, 1'b1, 1'b0, 32'd0, 0, 1'b0));
    applyStimulus(ld(4'h2, 1'b0, 32'hA000_0002));
    applyStimulus(mkv(1'b1, 1'b0, 1'b0, 4'h3, 32'd0, 1'b1, 1'b0, 32'd0, 0, 1'b0));
    waitIdle(n);

    // During a refill even a cached address is nacked and a store has no effect.
    ack_delay = 3;
    applyStimulus(ld(4'h0, 1'b1, 32'd0));
    applyStimulus(mkv(1'b1, 1'b0, 1'b0, 4'h5, 32'd0, 1'b1, 1'b0, 32'd0, 0, 1'b0));
    applyStimulus(mkv(1'b1, 1'b1, 1'b0, 4'h5, 32'h0000_0BAD, 1'b1, 1'b0, 32'd0, 0, 1'b0));
    waitIdle(n);
    applyStimulus(ld(4'h5, 1'b0, 32'h1234_5678));
    applyStimulus(ld(4'h0, 1'b0, 32'hA000_0000));

    // Reset in the middle of a refill abandons it and invalidates the cache.
    applyStimulus(ld(4'h8, 1'b1, 32'd0));
    checkOutput();
    checkValue("pre_reset_req", {31'd0, mem_o_req}, 32'd1);
    i_val = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkValue("reset_req_drop", {31'd0, mem_o_req}, 32'd0);
    checkValue("reset_nack", {31'd0, o_nack}, 32'd0);
    void'(mem_exp.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(ld(4'h5, 1'b1, 32'd0));
    waitIdle(n);
    applyStimulus(ld(4'h5, 1'b0, 32'h1234_5678));
    applyIdle();
    checkOutput();

    checkValue("mem_pending", mem_exp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through data cache that answers the load/store unit's request port (data, addr, we, kill in; data, nack out) and refills from or writes through to a word-wide backing memory over a req/ack handshake. Requests are presented in the LSU memory stage. Response data and nack are registered and consumed in the LSU writeback stage one cycle later. A nacked request has no side effect and must be reissued by the LSU.

## Interface
- WIDTH_MEM, 4: word-address width; same value as the LSU's WIDTH_MEM.
- WIDTH_IDX, 2: index bits; 2**WIDTH_IDX lines of one 32-bit word each; tag width = WIDTH_MEM-WIDTH_IDX (>=1).
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_val  in  1  request valid.
- i_addr  in  WIDTH_MEM  word address.
- i_data  in  32  store data.
- i_we  in  1  1 = store, 0 = load.
- i_kill  in  1  squash this cycle's request (branch kill / LAQ-SAQ conflict).
- o_data  out  32  load data, registered.
- o_nack  out  1  previous-cycle request rejected, registered.
- mem_o_req  out  1  memory request, registered.
- mem_o_we  out  1  memory write.
- mem_o_addr  out  WIDTH_MEM  memory word address.
- mem_o_data  out  32  memory write data.
- mem_i_data  in  32  memory read data, valid with ack.
- mem_i_ack  in  1  memory completes the current request.

## Operation
- Storage: per line a valid bit, tag and data word. Valid bits are cleared by reset; tag and data are not reset.
- Lookup: idx = i_addr[WIDTH_IDX-1:0]; tag = i_addr[WIDTH_MEM-1:WIDTH_IDX]; hit = valid[idx] && tag match.
- Accepted request = i_val && !i_kill. A killed request changes no state and drives o_nack=0 next cycle.
- FSM states:
  - IDLE:
    - Load hit: o_data <= line, o_nack <= 0.
    - Load miss: o_nack <= 1; latch address; go to REFILL.
    - Store: o_nack <= 0. On a hit, the line data is written. Latch addr/data; go to WRITE.
  - REFILL: mem_o_req=1, mem_o_we=0, mem_o_addr=latched address. On mem_i_ack: write line data=mem_i_data, set tag and valid; go to IDLE. Every request in this state is nacked.
  - WRITE: mem_o_req=1, mem_o_we=1, mem_o_addr/mem_o_data=latched. On mem_i_ack go to IDLE. Load hits are served normally. Load misses and stores are nacked, with no refill.
- Memory handshake: addr/we/data are stable while mem_o_req is high. The transfer completes in the first cycle with req && ack. req is low in the following cycle. At most one outstanding memory transaction.
- No request: o_nack <= 0, o_data holds.
- A kill does not abort an in-flight refill or write-through; the refill completes and installs the line.

## Timing
- Reset (async): state IDLE, all valid bits 0, o_data=0, o_nack=0, mem_o_req=0, mem_o_we=0, mem_o_addr=0, mem_o_data=0. Asserting reset mid-REFILL or mid-WRITE abandons the transaction; req drops immediately.
- Load hit at cycle N gives o_data/o_nack at N+1.
- Load miss at N: o_nack=1 at N+1; mem_o_req rises at N+1. With ack at cycle M, the line is written at the edge ending M and the FSM is IDLE at M+1. A retry at M+1 hits, with data at M+2.
- Store at N (IDLE): the line is updated at the edge ending N. mem_o_req rises at N+1. The FSM is busy until the ack edge.
- A request in the ack cycle of REFILL/WRITE is still handled by that state's rules (REFILL: nack).
- i_kill is sampled in the same cycle as the request. A killed store never writes the array or memory.

## Configuration
- DCACHE_WRALLOC_EN defined: a store miss in IDLE installs the line (tag, valid=1, data=i_data). Write-through to memory is unchanged.
- Not defined: a store miss leaves the array unchanged (no-write-allocate).

## Test plan
- Reset, then load addr 0x5 with memory[5]=0xDEADBEEF, ack after 3 cycles -> nack=1 at N+1; req held for 3 cycles; retry after return to IDLE -> o_data=0xDEADBEEF, nack=0.
- Store 0x12345678 to cached addr 0x5 -> mem write addr 5 data 0x12345678. A load 0x5 during WRITE -> o_data=0x12345678, nack=0. A store during WRITE -> nack=1.
- Store to uncached addr 0x9, then load 0x9 after the ack -> without the macro: nack=1 (refill); with DCACHE_WRALLOC_EN: hit, returns the stored value.
- Store with i_kill=1 -> no mem_o_req, array unchanged, o_nack=0. Load miss with i_kill=1 -> no refill.
- Addresses 0x1 and 0x5 (same index, WIDTH_IDX=2) alternately loaded -> each access misses after the other's refill (conflict eviction).
- Assert i_rst_n low mid-REFILL -> mem_o_req=0 immediately; after release, the previously cached address misses.
